issue_scoreboard: RTL
=====================

Name: issue_scoreboard

Overview:
- Sits between the decode stage and execute. Holds each decoded instruction until its source and destination registers are free of in-flight writes.
- Tracks one pending write per architectural register (RV32E, x0–x15) with a busy-bit scoreboard, cleared by writeback.
- Provides a single registered output stage with valid/ready handshakes on both sides, plus a flush input for branch/jump redirects.

Parameters:
- DATA_W, 32, width of the opaque decoded-instruction payload passed through to execute
- NUM_REGS, 16, number of architectural registers tracked (RV32E)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- up_valid  in  1  decode presents an instruction
- up_ready  out  1  scoreboard accepts the instruction this cycle
- up_data  in  DATA_W  decoded payload
- up_opcode  in  7  instruction opcode field
- up_rs1  in  5  source register 1 index
- up_rs2  in  5  source register 2 index
- up_rd  in  5  destination register index
- dn_valid  out  1  output register holds an instruction
- dn_ready  in  1  execute accepts it
- dn_data  out  DATA_W  registered payload
- dn_illegal  out  1  issued instruction used a register index ≥ NUM_REGS or an unknown opcode
- wb_valid  in  1  execute retires a register write
- wb_rd  in  5  register written back
- flush  in  1  discard the output stage (redirect)
- busy  out  NUM_REGS  scoreboard bits, for debug and verification

Behaviour:
- Reset (asynchronous, active-high) sets all outputs to zero: busy=0, dn_valid=0, dn_data=0, dn_illegal=0. up_ready is combinational and evaluates to 1 after reset.
- Register usage per opcode:
  - LUI, AUIPC, JAL: rd only.
  - JALR, OP_IMM, LOAD: rs1 and rd.
  - OP_REG: rs1, rs2 and rd.
  - BRANCH, STORE: rs1 and rs2.
  - MISC_MEM: none.
  - SYSTEM: none, but serialising.
  - Any other opcode: no registers used; issued with dn_illegal=1.
- Index x0 is never busy and never hazards. rd=x0 never sets a busy bit.
- A used index ≥ NUM_REGS:
  - Not checked for hazards and not marked busy.
  - Issues with dn_illegal=1.
- Effective busy = busy & ~(wb_valid ? onehot(wb_rd) : 0). Writeback in the same cycle counts as already clear (bypass).
- Hazard when any of the following holds:
  - A used rs1 or rs2 is effectively busy (RAW).
  - The used rd is effectively busy (WAW).
  - The instruction is SYSTEM and either effective busy≠0 or dn_valid=1.
- Issue condition: up_ready = !flush && !hazard && (!dn_valid || dn_ready). A transfer occurs when up_valid && up_ready.
- Latency: one cycle. An accepted instruction appears on dn_valid at the next edge.
- Output stage:
  - On transfer: load dn_data and dn_illegal, set dn_valid=1.
  - Else if dn_ready: clear dn_valid.
  - dn_data holds its value while dn_valid && !dn_ready.
- Busy update at the clock edge:
  - The issued rd bit is set.
  - The wb_rd bit is cleared when wb_valid.
  - If both target the same register, set wins.
- Flush:
  - dn_valid is cleared at the edge.
  - The busy bit of the flushed instruction's rd is cleared if dn_valid was set and that instruction wrote a register. The output stage keeps a stored rd/writes-rd tag for this.
  - No transfer occurs in a flush cycle.
  - Instructions already handed to execute keep their busy bits.
- Spurious wb_valid to a non-busy register, x0, or an index ≥ NUM_REGS: no effect.
- Reset asserted mid-operation clears the scoreboard and the output stage immediately. Pending writebacks after reset are ignored.

Decomposition:
- Shared package: the opcode enum (LUI, AUIPC, JAL, JALR, OP_IMM, OP_REG, BRANCH, LOAD, STORE, MISC_MEM, SYSTEM), NUM_REGS, and a reg_usage struct {uses_rs1, uses_rs2, uses_rd, serialise, illegal}.
- One combinational sub-module, reg_usage_decode, maps opcode to reg_usage.
- The scoreboard and the output stage live in issue_scoreboard.

Test Plan:
- Back-to-back independence:
  - Stimulus: ADDI x1,x0 then ADDI x2,x0, dn_ready=1.
  - Response: both issue on consecutive cycles; busy=0x0006 afterwards.
- RAW stall:
  - Stimulus: ADDI x3 issued, then ADD x4,x3,x3.
  - Response: up_ready=0 while busy[3]=1. wb_valid, wb_rd=3 in the same cycle gives up_ready=1 that cycle; busy ends at 0x0010.
- WAW plus set-wins:
  - Stimulus: ADDI x5 issued; later wb_rd=5 coincides with a new ADDI x5.
  - Response: busy[5] stays 1.
- Backpressure:
  - Stimulus: dn_ready=0 for 3 cycles after one issue.
  - Response: dn_valid=1 and dn_data stable; up_ready=0; the second instruction issues the cycle after dn_ready=1.
- Flush:
  - Stimulus: LUI x6 in the output stage (busy[6]=1) with flush=1.
  - Response: next cycle dn_valid=0, busy[6]=0; no transfer during the flush cycle.
- SYSTEM serialisation and illegal index:
  - Stimulus: ECALL while busy=0x0002; then ADDI with rd=17.
  - Response: ECALL waits until wb_rd=1 arrives. The ADDI issues with dn_illegal=1 and busy unchanged.

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue scoreboard: RV32 opcodes, register count
// and the per-opcode register-usage descriptor.
package issue_scoreboard_pkg;

   localparam int NUM_REGS = 16;

   typedef enum logic [6:0] {
      LUI      = 7'b0110111,
      AUIPC    = 7'b0010111,
      JAL      = 7'b1101111,
      JALR     = 7'b1100111,
      OP_IMM   = 7'b0010011,
      OP_REG   = 7'b0110011,
      BRANCH   = 7'b1100011,
      LOAD     = 7'b0000011,
      STORE    = 7'b0100011,
      MISC_MEM = 7'b0001111,
      SYSTEM   = 7'b1110011
   } opcode_e;

   typedef struct packed {
      logic uses_rs1;
      logic uses_rs2;
      logic uses_rd;
      logic serialise;
      logic illegal;
   } reg_usage_t;

endpackage

// File: rtl/issue_scoreboard_reg_usage_decode.sv
// Maps an instruction opcode to the set of register fields it consumes or writes.
module reg_usage_decode
   import issue_scoreboard_pkg::*;
(
   input  logic [6:0] opcode,
   output reg_usage_t usage
);

   always_comb begin
      usage = '0;
      case (opcode)
         LUI, AUIPC, JAL:     usage.uses_rd = 1'b1;
         JALR, OP_IMM, LOAD: begin
            usage.uses_rs1 = 1'b1;
            usage.uses_rd  = 1'b1;
         end
         OP_REG: begin
            usage.uses_rs1 = 1'b1;
            usage.uses_rs2 = 1'b1;
            usage.uses_rd  = 1'b1;
         end
         BRANCH, STORE: begin
            usage.uses_rs1 = 1'b1;
            usage.uses_rs2 = 1'b1;
         end
         MISC_MEM:            ;
         SYSTEM:              usage.serialise = 1'b1;
         default:             usage.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-to-execute issue stage: busy-bit scoreboard over the architectural
// registers plus one registered output slot with valid/ready on both sides.
module issue_scoreboard
   import issue_scoreboard_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = issue_scoreboard_pkg::NUM_REGS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                up_valid,
   output logic                up_ready,
   input  logic [DATA_W-1:0]   up_data,
   input  logic [6:0]          up_opcode,
   input  logic [4:0]          up_rs1,
   input  logic [4:0]          up_rs2,
   input  logic [4:0]          up_rd,
   output logic                dn_valid,
   input  logic                dn_ready,
   output logic [DATA_W-1:0]   dn_data,
   output logic                dn_illegal,
   input  logic                wb_valid,
   input  logic [4:0]          wb_rd,
   input  logic                flush,
   output logic [NUM_REGS-1:0] busy
);

   function automatic logic in_range(input logic [4:0] idx);
      return int'(idx) < NUM_REGS;
   endfunction

   // x0 and out-of-range indices map to an empty mask, so they never hazard or set busy
   function automatic logic [NUM_REGS-1:0] reg_mask(input logic [4:0] idx);
      if (in_range(idx) && idx != 5'd0)
         return {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
      return '0;
   endfunction

   reg_usage_t          usage;
   logic [NUM_REGS-1:0] wb_mask, eff_busy, rs1_mask, rs2_mask, rd_mask;
   logic [NUM_REGS-1:0] set_mask, flush_mask;
   logic                hazard, illegal, xfer;
   logic [4:0]          dn_rd;
   logic                dn_wr_rd;

   reg_usage_decode u_decode (
      .opcode (up_opcode),
      .usage  (usage)
   );

   always_comb begin
      wb_mask  = wb_valid ? reg_mask(wb_rd) : '0;
      eff_busy = busy & ~wb_mask;
      rs1_mask = usage.uses_rs1 ? reg_mask(up_rs1) : '0;
      rs2_mask = usage.uses_rs2 ? reg_mask(up_rs2) : '0;
      rd_mask  = usage.uses_rd  ? reg_mask(up_rd)  : '0;

      hazard = |((rs1_mask | rs2_mask | rd_mask) & eff_busy)
             | (usage.serialise && ((|eff_busy) || dn_valid));

      illegal = usage.illegal
              | (usage.uses_rs1 && !in_range(up_rs1))
              | (usage.uses_rs2 && !in_range(up_rs2))
              | (usage.uses_rd  && !in_range(up_rd));

      up_ready = !flush && !hazard && (!dn_valid || dn_ready);
      xfer     = up_valid && up_ready;

      set_mask   = xfer ? rd_mask : '0;
      flush_mask = (flush && dn_valid && dn_wr_rd) ? reg_mask(dn_rd) : '0;
   end

   // Set is applied after the clears so a same-cycle writeback to the new rd loses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy <= '0;
      end else begin
         busy <= (busy & ~wb_mask & ~flush_mask) | set_mask;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dn_valid   <= 1'b0;
         dn_data    <= '0;
         dn_illegal <= 1'b0;
         dn_rd      <= '0;
         dn_wr_rd   <= 1'b0;
      end else if (flush) begin
         dn_valid <= 1'b0;
      end else if (xfer) begin
         dn_valid   <= 1'b1;
         dn_data    <= up_data;
         dn_illegal <= illegal;
         dn_rd      <= up_rd;
         dn_wr_rd   <= |rd_mask;
      end else if (dn_ready) begin
         dn_valid <= 1'b0;
      end
   end

endmodule
